dmem_responder: RTL and testbench

//  Memory-side responder for the CPU data-memory port (mem_ce/memwrite/mem_sel/dataadr/writedata/readdata).

---
 rtl/dmem_responder_pkg.sv | 30 +++
 rtl/dmem_responder_byte_lane_ram.sv | 28 ++
 rtl/dmem_responder.sv | 104 ++++++++++
 tb/tb_dmem_responder.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the data-memory responder: FSM states and byte-select legality.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package dmem_responder_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Byte selects the CPU may legally issue: single bytes, aligned halves, full word.
  localparam logic [3:0] SEL_B0  = 4'b0001;
  localparam logic [3:0] SEL_B1  = 4'b0010;
  localparam logic [3:0] SEL_B2  = 4'b0100;
  localparam logic [3:0] SEL_B3  = 4'b1000;
  localparam logic [3:0] SEL_HLO = 4'b0011;
  localparam logic [3:0] SEL_HHI = 4'b1100;
  localparam logic [3:0] SEL_W   = 4'b1111;

  function automatic logic sel_legal(input logic [3:0] sel);
    logic ok;
    case (sel)
      SEL_B0, SEL_B1, SEL_B2, SEL_B3, SEL_HLO, SEL_HHI, SEL_W: ok = 1'b1;
      default:                                                ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/dmem_responder_byte_lane_ram.sv
// Word-wide RAM with one write enable per byte lane.
// Latency: write commits on the clock edge, read is asynchronous (same cycle).
// Backpressure: none; always ready.
module byte_lane_ram #(
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic [3:0]        we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [31:0] mem [DEPTH];

  // Lane-wise write; lanes with a clear enable keep their old byte.
  always_ff @(posedge clk) begin
    if (we[0]) mem[addr][7:0]   <= wdata[7:0];
    if (we[1]) mem[addr][15:8]  <= wdata[15:8];
    if (we[2]) mem[addr][23:16] <= wdata[23:16];
    if (we[3]) mem[addr][31:24] <= wdata[31:24];
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/dmem_responder.sv
// Slow data-memory responder: latches one CPU load/store, waits, then commits it to a byte-lane RAM.
// Latency: WAIT_CYCLES+2 cycles from request to DONE (IDLE accept, BUSY countdown, DONE result).
// Backpressure: mem_stall holds the CPU while a request is pending; low only in DONE.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int          ADDR_W      = 6,
  parameter int          WAIT_CYCLES = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_ce,
  input  logic        memwrite,
  input  logic [3:0]  mem_sel,
  input  logic [31:0] dataadr,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        mem_stall,
  output logic        mem_err
);

  localparam int          DEPTH = 1 << ADDR_W;
  // Span in bytes, one bit wider so a full 4 GiB window cannot overflow.
  localparam logic [32:0] SPAN  = 33'(DEPTH) << 2;

  state_t              state, state_nxt;
  logic [3:0]          cnt;
  logic                req_we;
  logic [3:0]          req_sel;
  logic [31:0]         req_adr;
  logic [31:0]         req_wd;
  logic [31:0]         offset;
  logic [ADDR_W-1:0]   word;
  logic                legal;
  logic                commit;
  logic [3:0]          lane_we;
  logic [31:0]         ram_rd;

  // Everything downstream works off the latched request, never the live bus.
  assign offset  = req_adr - BASE_ADDR;
  assign word    = offset[ADDR_W+1:2];
  assign legal   = sel_legal(req_sel) && ({1'b0, offset} < SPAN);
  // A reset landing on the commit edge must not let the store through.
  assign lane_we = (commit && req_we && legal && !rst) ? req_sel : 4'b0000;

  byte_lane_ram #(.ADDR_W(ADDR_W)) u_ram (
    .clk   (clk),
    .we    (lane_we),
    .addr  (word),
    .wdata (req_wd),
    .rdata (ram_rd)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next state, stall and commit strobe.
  always_comb begin
    state_nxt = state;
    commit    = 1'b0;
    mem_stall = mem_ce && (state != S_DONE);
    case (state)
      S_IDLE: if (mem_ce) state_nxt = S_BUSY;
      S_BUSY: if (cnt == 4'd0) begin
                commit    = 1'b1;
                state_nxt = S_DONE;
              end
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Request capture, wait countdown and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= 4'd0;
      req_we   <= 1'b0;
      req_sel  <= 4'd0;
      req_adr  <= 32'd0;
      req_wd   <= 32'd0;
      readdata <= 32'd0;
      mem_err  <= 1'b0;
    end else begin
      mem_err <= 1'b0;
      if (state == S_IDLE && mem_ce) begin
        req_we  <= memwrite;
        req_sel <= mem_sel;
        req_adr <= dataadr;
        req_wd  <= writedata;
        cnt     <= 4'(WAIT_CYCLES);
      end
      if (state == S_BUSY && cnt != 4'd0) cnt <= cnt - 4'd1;
      if (commit) begin
        mem_err  <= !legal;
        readdata <= (legal && !req_we) ? ram_rd : 32'd0;
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized self-checking bench for dmem_responder: two instances (2 and 0 wait states).
// Latency: expected stall per access is wait states + 2.
// Backpressure: bench holds each request until mem_stall drops, then frees the bus.
module tb_dmem_responder;

  localparam int NWORDS = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic        ce    [2];
  logic        we    [2];
  logic [3:0]  sel   [2];
  logic [31:0] adr   [2];
  logic [31:0] wd    [2];
  logic [31:0] rd    [2];
  logic        stall [2];
  logic        err   [2];

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] mdl [2][NWORDS];
  logic [3:0]  legal_sels [7] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111};

  always #5 clk = ~clk;

  // Index 0: no wait states; index 1: two wait states.
  dmem_responder #(.ADDR_W(6), .WAIT_CYCLES(0), .BASE_ADDR(32'h0)) u_dut_w0 (
    .clk(clk), .rst(rst), .mem_ce(ce[0]), .memwrite(we[0]), .mem_sel(sel[0]),
    .dataadr(adr[0]), .writedata(wd[0]), .readdata(rd[0]), .mem_stall(stall[0]), .mem_err(err[0])
  );

  dmem_responder #(.ADDR_W(6), .WAIT_CYCLES(2), .BASE_ADDR(32'h0)) u_dut_w2 (
    .clk(clk), .rst(rst), .mem_ce(ce[1]), .memwrite(we[1]), .mem_sel(sel[1]),
    .dataadr(adr[1]), .writedata(wd[1]), .readdata(rd[1]), .mem_stall(stall[1]), .mem_err(err[1])
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One complete access; expectations come from the byte-array model.
  task automatic access(input int d, input logic w, input logic [3:0] s,
                        input logic [31:0] a, input logic [31:0] data, input string tag);
    logic        ok;
    logic [31:0] exp_rd;
    int          wi;
    int          n;
    int          wait_states;
    wait_states = (d == 0) ? 0 : 2;
    ok = (s inside {4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111}) &&
         (a < 32'(NWORDS * 4));
    wi = int'(a / 4) % NWORDS;
    exp_rd = 32'd0;
    if (ok && w) begin
      for (int i = 0; i < 4; i++)
        if (s[i]) mdl[d][wi][8*i +: 8] = data[8*i +: 8];
    end else if (ok) begin
      exp_rd = mdl[d][wi];
    end
    ce[d] = 1'b1; we[d] = w; sel[d] = s; adr[d] = a; wd[d] = data;
    #1;
    n = 0;
    while (stall[d] && n < 40) begin
      n++;
      @(negedge clk); #1;
      // Bus garbage while waiting must not disturb the latched request.
      if (stall[d]) begin
        adr[d] = $urandom; wd[d] = $urandom; sel[d] = 4'($urandom); we[d] = ~w;
      end
    end
    check({tag, ":stall"}, 32'(n), 32'(wait_states + 2));
    check({tag, ":rd"}, rd[d], exp_rd);
    check({tag, ":err"}, {31'd0, err[d]}, {31'd0, !ok});
    ce[d] = 1'b0;
    @(negedge clk); #1;
    check({tag, ":err_clr"}, {31'd0, err[d]}, 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    int          last_w;
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      ce[d] = 1'b0; we[d] = 1'b0; sel[d] = 4'd0; adr[d] = 32'd0; wd[d] = 32'd0;
    end
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      check("rst:rd", rd[d], 32'd0);
      check("rst:err", {31'd0, err[d]}, 32'd0);
      check("rst:stall", {31'd0, stall[d]}, 32'd0);
    end

    // Zero every word through the bus so the model starts from known contents.
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < NWORDS; i++)
        access(d, 1'b1, 4'b1111, 32'(i * 4), 32'd0, "fill");

    // Directed cases on the two-wait-state instance.
    access(1, 1'b0, 4'b1111, 32'h00, 32'd0,        "ld0");
    access(1, 1'b1, 4'b1111, 32'h10, 32'hDEADBEEF, "st10");
    access(1, 1'b0, 4'b1111, 32'h10, 32'd0,        "ld10");
    access(1, 1'b1, 4'b0010, 32'h11, 32'h0000AB00, "stb11");
    access(1, 1'b0, 4'b1111, 32'h10, 32'd0,        "ld10b");
    check("ld10b:value", mdl[1][4], 32'hDEADABEF);
    access(1, 1'b1, 4'b1111, 32'h20, 32'h55667788, "st20");
    access(1, 1'b1, 4'b0101, 32'h20, 32'hFFFFFFFF, "st20bad");
    access(1, 1'b0, 4'b1111, 32'h20, 32'd0,        "ld20");
    access(1, 1'b0, 4'b1111, 32'h100, 32'd0,       "ld_oor");
    access(1, 1'b0, 4'b1111, 32'hFFFF_FFFC, 32'd0, "ld_wrap");

    // Reset during BUSY of a store abandons it.
    access(1, 1'b1, 4'b1111, 32'h30, 32'hA5A5A5A5, "st30");
    access(1, 1'b0, 4'b1111, 32'h30, 32'd0,        "ld30");
    ce[1] = 1'b1; we[1] = 1'b1; sel[1] = 4'b1111; adr[1] = 32'h30; wd[1] = 32'h12345678;
    @(negedge clk); @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; ce[1] = 1'b0;
    #1;
    check("rstmid:rd", rd[1], 32'd0);
    check("rstmid:err", {31'd0, err[1]}, 32'd0);
    access(1, 1'b0, 4'b1111, 32'h30, 32'd0, "ld30post");

    // Zero-wait instance: back-to-back alternating store/load.
    last_w = 0;
    for (int i = 0; i < 16; i++) begin
      if (i % 2 == 0) begin
        last_w = $urandom_range(0, NWORDS - 1);
        a = 32'(last_w * 4 + $urandom_range(0, 3));
        access(0, 1'b1, legal_sels[$urandom_range(0, 6)], a, $urandom, "b2b_st");
      end else begin
        a = (i % 4 == 1) ? 32'(last_w * 4) : 32'($urandom_range(0, NWORDS - 1) * 4);
        access(0, 1'b0, 4'b1111, a, 32'd0, "b2b_ld");
      end
    end

    // Mixed random traffic including illegal selects and out-of-range addresses.
    for (int i = 0; i < 12; i++) begin
      access(1, 1'($urandom), 4'($urandom), 32'($urandom_range(0, 300)), $urandom, "rnd");
    end
    for (int i = 0; i < NWORDS; i += 9)
      access(1, 1'b0, 4'b1111, 32'(i * 4), 32'd0, "sweep");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
